button_cont: RTL and testbench
==============================

Name: button_cont

Overview:
- CPU-readable push-button input controller. It is the input-direction counterpart to the LED output register on the same 2-bit-address, 16-bit local peripheral bus.
- Synchronizes and debounces NUM_BTN button lines and exposes their debounced state.
- Latches press events in write-1-to-clear flags and raises a maskable, registered interrupt to the CPU interrupt controller.

Parameters:
- NUM_BTN, 3, number of button inputs (1..16).
- DEBOUNCE_CYC, 50000, Clk cycles a synchronized level must hold before it is accepted (>=2).
- CNT_W, 16, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYC.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-low reset (0 = reset).
- Addr  input  2  register select.
- DataRd  output  16  read data.
- DataWr  input  16  write data.
- En  input  1  block select.
- Rd  input  1  read strobe (no side effects).
- Wr  input  1  write strobe; a write occurs when Wr & En at a rising Clk.
- Btn  input  NUM_BTN  raw asynchronous buttons, active-high (1 = pressed).
- Irq  output  1  level interrupt, registered.

Behaviour:
- Register map (unused upper bits read 0):
  - Addr 0 STATE (RO): debounced state.
  - Addr 1 EVENT (R/W1C): sticky press flags.
  - Addr 2 IRQEN (RW): per-button interrupt enable.
  - Addr 3 RAW (RO): synchronizer outputs.
- DataRd is combinational from Addr and register contents, with no x.
- Writes to Addr 0 and Addr 3 are ignored.
- Reset (Reset==0 at a rising Clk) clears:
  - synchronizer flops, debounce counters, STATE, EVENT, IRQEN, Irq.
  - The block then starts from "all released". Reset mid-debounce discards the count.
- Synchronizer: two flops per bit. sync[i] follows Btn[i] 2 cycles late.
- Debounce, per bit:
  - If sync != STATE: cnt increments each cycle.
  - When cnt == DEBOUNCE_CYC-1 and sync still != STATE: at the next edge, STATE <= sync and cnt <= 0.
  - If sync == STATE: cnt <= 0, so any glitch restarts the count.
  - Net effect: a level must differ from STATE for DEBOUNCE_CYC consecutive cycles.
- Latency from a clean Btn edge:
  - sync changes after 2 edges.
  - STATE changes DEBOUNCE_CYC edges later.
  - EVENT sets 1 edge after the STATE rise.
  - Irq asserts 1 edge after that.
- Release (STATE 1->0) sets no flag.
- EVENT:
  - Bit i sets on the cycle after STATE[i] rises.
  - A write to Addr 1 clears every bit where DataWr[i]==1.
  - Simultaneous set and clear of the same bit: set wins, so no press is lost.
  - Repeat presses while a flag is already set leave it at 1; presses are not counted.
- IRQEN: a write to Addr 2 loads DataWr[NUM_BTN-1:0].
- Irq <= |(EVENT & IRQEN), registered.
  - Disabling a bit deasserts Irq on the next edge.
  - Enabling a bit whose flag is already set asserts Irq on the next edge.
- Counter width: cnt saturates by construction and never wraps, because it resets at DEBOUNCE_CYC-1.

Decomposition:
- Shared package holds:
  - address constants BTN_ADDR_STATE=2'd0, BTN_ADDR_EVENT=2'd1, BTN_ADDR_IRQEN=2'd2, BTN_ADDR_RAW=2'd3;
  - the 16-bit bus data width constant.
- Sub-module btn_debounce (one instance per bit, generate loop):
  - contains the 2-flop synchronizer, cnt, and stable bit;
  - outputs sync and stable.
- The top level holds EVENT, IRQEN, Irq and read/write decode.

Test Plan (DEBOUNCE_CYC=4, NUM_BTN=3):
- Reset held low 3 cycles, Btn=3'b111 during reset.
  - Required: STATE, EVENT, IRQEN read 0 and Irq=0 throughout reset.
  - After release, STATE=3'b111 at edge 6 and EVENT=3'b111 at edge 7.
- Btn[0] 0->1 held.
  - Required: RAW=1 after 2 edges, STATE=16'h0001 after 6 edges, EVENT=16'h0001 after 7.
  - Irq stays 0 while IRQEN=0.
- Btn[1] pulses high for 3 cycles, then low (glitch shorter than debounce).
  - Required: STATE and EVENT stay 0 and no Irq.
  - A subsequent 6-cycle hold sets STATE[1] and EVENT[1].
- Write IRQEN=16'h0002 while EVENT[1]=1.
  - Required: Irq=1 on the next edge.
  - Write Addr1 DataWr=16'h0002: EVENT=0 and Irq=0 one edge later.
- Arrange the write-1-to-clear of bit 2 on the same edge EVENT[2] would set.
  - Required: EVENT[2] reads 1 afterwards (set wins).
- Write Addr 0 with 16'hFFFF and Addr 3 with 16'hFFFF.
  - Required: STATE and RAW unchanged.
  - Read Addr 3 with Btn=3'b101 held: DataRd=16'h0005.

Source files
------------

// File: rtl/button_cont_pkg.sv
// Shared constants for the push-button controller: register map and bus width.
package button_cont_pkg;

   localparam int BTN_BUS_W = 16;

   localparam logic [1:0] BTN_ADDR_STATE = 2'd0;
   localparam logic [1:0] BTN_ADDR_EVENT = 2'd1;
   localparam logic [1:0] BTN_ADDR_IRQEN = 2'd2;
   localparam logic [1:0] BTN_ADDR_RAW   = 2'd3;

endpackage

// File: rtl/button_cont_debounce.sv
// One button lane: two-flop synchronizer followed by a hold-time debouncer.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 50000,
   parameter int CNT_W        = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_i,
   output logic sync_o,
   output logic stable_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             meta_q;
   logic             sync_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Any cycle where the synchronized level matches the accepted state restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         meta_q   <= btn_i;
         sync_q   <= meta_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign sync_o   = sync_q;
   assign stable_o = stable_q;

endmodule

// File: rtl/button_cont.sv
// CPU-readable push-button controller: debounced state, sticky press flags,
// per-button interrupt enables and a registered level interrupt.
module button_cont
   import button_cont_pkg::*;
#(
   parameter int NUM_BTN      = 3,
   parameter int DEBOUNCE_CYC = 50000,
   parameter int CNT_W        = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [1:0]           Addr,
   output logic [BTN_BUS_W-1:0] DataRd,
   input  logic [BTN_BUS_W-1:0] DataWr,
   input  logic                 En,
   input  logic                 Rd,
   input  logic                 Wr,
   input  logic [NUM_BTN-1:0]   Btn,
   output logic                 Irq
);

   logic [NUM_BTN-1:0]   sync;
   logic [NUM_BTN-1:0]   state;
   logic [NUM_BTN-1:0]   state_prev_q;
   logic [NUM_BTN-1:0]   event_q;
   logic [NUM_BTN-1:0]   event_d;
   logic [NUM_BTN-1:0]   irqen_q;
   logic [NUM_BTN-1:0]   irqen_d;
   logic [NUM_BTN-1:0]   clr_mask;
   logic                 irq_q;
   logic                 irq_d;
   logic                 wr_event;
   logic                 wr_irqen;
   logic [BTN_BUS_W-1:0] rd_data;
   logic                 unused_bus;

   // Reads have no side effects, so the strobe carries no information here.
   assign unused_bus = ^{Rd, DataWr};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .CNT_W        (CNT_W)
      ) u_debounce (
         .clk_i    (Clk),
         .rst_n_i  (Reset),
         .btn_i    (Btn[g]),
         .sync_o   (sync[g]),
         .stable_o (state[g])
      );
   end

   assign wr_event = Wr & En & (Addr == BTN_ADDR_EVENT);
   assign wr_irqen = Wr & En & (Addr == BTN_ADDR_IRQEN);
   assign clr_mask = wr_event ? DataWr[NUM_BTN-1:0] : '0;

   // A fresh press is OR-ed in after the clear so a coincident W1C never drops it.
   always_comb begin
      event_d = (event_q & ~clr_mask) | (state & ~state_prev_q);
      irqen_d = wr_irqen ? DataWr[NUM_BTN-1:0] : irqen_q;
      irq_d   = |(event_q & irqen_q);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_prev_q <= '0;
         event_q      <= '0;
         irqen_q      <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_prev_q <= state;
         event_q      <= event_d;
         irqen_q      <= irqen_d;
         irq_q        <= irq_d;
      end
   end

   always_comb begin
      rd_data = '0;
      case (Addr)
         BTN_ADDR_STATE: rd_data[NUM_BTN-1:0] = state;
         BTN_ADDR_EVENT: rd_data[NUM_BTN-1:0] = event_q;
         BTN_ADDR_IRQEN: rd_data[NUM_BTN-1:0] = irqen_q;
         BTN_ADDR_RAW:   rd_data[NUM_BTN-1:0] = sync;
      endcase
   end

   assign DataRd = rd_data;
   assign Irq    = irq_q;

endmodule

// File: tb/tb_button_cont.sv
// Self-checking bench for button_cont: window-based reference model checked
// every cycle, plus directed register reads with hand-computed values.
module tb_button_cont;

   localparam int NB  = 3;
   localparam int DEB = 4;
   localparam int CW  = 3;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [1:0]    Addr;
   logic [15:0]   DataRd;
   logic [15:0]   DataWr;
   logic          En;
   logic          Rd;
   logic          Wr;
   logic [NB-1:0] Btn;
   logic          Irq;

   int n_assert = 0;
   int n_fail   = 0;

   always #10 Clk = ~Clk;

   button_cont #(
      .NUM_BTN      (NB),
      .DEBOUNCE_CYC (DEB),
      .CNT_W        (CW)
   ) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Addr   (Addr),
      .DataRd (DataRd),
      .DataWr (DataWr),
      .En     (En),
      .Rd     (Rd),
      .Wr     (Wr),
      .Btn    (Btn),
      .Irq    (Irq)
   );

   // Reference model: a level is accepted once the last DEB synchronized
   // samples all differ from the accepted state.
   logic [NB-1:0] m_state = '0, m_event = '0, m_irqen = '0;
   logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_rise = '0;
   logic [NB-1:0] m_hist [DEB];
   logic          m_irq = 1'b0;
   bit            m_live = 1'b0;

   always @(posedge Clk) begin : model
      logic [NB-1:0] st_n;
      logic [NB-1:0] clr;
      bit            differ;
      m_live = 1'b1;
      if (!Reset) begin
         m_state = '0; m_event = '0; m_irqen = '0; m_irq = 1'b0;
         m_s1 = '0; m_s2 = '0; m_rise = '0;
         for (int j = 0; j < DEB; j++) m_hist[j] = '0;
      end else begin
         for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = m_s2;
         st_n = m_state;
         for (int i = 0; i < NB; i++) begin
            differ = 1'b1;
            for (int j = 0; j < DEB; j++)
               if (m_hist[j][i] == m_state[i]) differ = 1'b0;
            if (differ) st_n[i] = ~m_state[i];
         end
         clr     = (Wr && En && Addr == 2'd1) ? DataWr[NB-1:0] : '0;
         m_irq   = |(m_event & m_irqen);
         m_event = (m_event & ~clr) | m_rise;
         if (Wr && En && Addr == 2'd2) m_irqen = DataWr[NB-1:0];
         m_rise  = st_n & ~m_state;
         m_state = st_n;
         m_s2    = m_s1;
         m_s1    = Btn;
      end
   end

   function automatic logic [15:0] m_read(input logic [1:0] a);
      logic [15:0] r;
      r = '0;
      case (a)
         2'd0: r[NB-1:0] = m_state;
         2'd1: r[NB-1:0] = m_event;
         2'd2: r[NB-1:0] = m_irqen;
         2'd3: r[NB-1:0] = m_s2;
      endcase
      return r;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (m_live) begin
         chk("model_datard", DataRd, m_read(Addr));
         chk("model_irq", {15'd0, Irq}, {15'd0, m_irq});
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [15:0] e, input string nm);
      Addr = a;
      Rd   = 1'b1;
      #1;
      chk(nm, DataRd, e);
      Rd   = 1'b0;
   endtask

   task automatic chk_irq(input logic e, input string nm);
      chk(nm, {15'd0, Irq}, {15'd0, e});
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      Addr   = a;
      DataWr = d;
      En     = 1'b1;
      Wr     = 1'b1;
      tick(1);
      Wr     = 1'b0;
      En     = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; Btn = 3'b111; En = 1'b0; Wr = 1'b0; Rd = 1'b0;
      Addr = 2'd0; DataWr = 16'h0000;

      for (int k = 0; k < 3; k++) begin
         tick(1);
         rd(2'd0, 16'h0000, "rst_state");
         rd(2'd1, 16'h0000, "rst_event");
         rd(2'd2, 16'h0000, "rst_irqen");
         chk_irq(1'b0, "rst_irq");
      end
      Reset = 1'b1;
      tick(5); rd(2'd0, 16'h0000, "state_e5");
      tick(1); rd(2'd0, 16'h0007, "state_e6");
      tick(1); rd(2'd1, 16'h0007, "event_e7");
      tick(1); chk_irq(1'b0, "irq_disabled");
      wr(2'd1, 16'h0007); rd(2'd1, 16'h0000, "event_w1c_all");

      // Release: state drops, no flag.
      Btn = 3'b000;
      tick(8);
      rd(2'd0, 16'h0000, "state_release");
      rd(2'd1, 16'h0000, "event_release");

      Btn = 3'b001;
      tick(1); rd(2'd3, 16'h0000, "raw_e1");
      tick(1); rd(2'd3, 16'h0001, "raw_e2");
      tick(3); rd(2'd0, 16'h0000, "btn0_state_e5");
      tick(1); rd(2'd0, 16'h0001, "btn0_state_e6");
      tick(1); rd(2'd1, 16'h0001, "btn0_event_e7");
      tick(1); chk_irq(1'b0, "btn0_no_irq");
      wr(2'd1, 16'h0001);

      // Three-cycle glitch is one short of the debounce window.
      Btn = 3'b011; tick(3);
      Btn = 3'b001; tick(10);
      rd(2'd0, 16'h0001, "glitch_state");
      rd(2'd1, 16'h0000, "glitch_event");
      chk_irq(1'b0, "glitch_irq");
      Btn = 3'b011;
      tick(6); rd(2'd0, 16'h0003, "hold_state");
      tick(1); rd(2'd1, 16'h0002, "hold_event");

      wr(2'd2, 16'h0002); chk_irq(1'b0, "irq_before_en");
      tick(1); chk_irq(1'b1, "irq_enabled");
      wr(2'd1, 16'h0002);
      rd(2'd1, 16'h0000, "event_clr1");
      chk_irq(1'b1, "irq_lag");
      tick(1); chk_irq(1'b0, "irq_cleared");

      // W1C of bit 2 lands on the edge its flag sets.
      Btn = 3'b111;
      tick(6);
      wr(2'd1, 16'h0004);
      rd(2'd1, 16'h0004, "set_wins");
      wr(2'd2, 16'h0004);
      tick(1); chk_irq(1'b1, "irq_en2");
      wr(2'd2, 16'h0000); chk_irq(1'b1, "irq_dis_lag");
      tick(1); chk_irq(1'b0, "irq_disabled2");

      wr(2'd0, 16'hFFFF);
      wr(2'd3, 16'hFFFF);
      rd(2'd0, 16'h0007, "state_ro");
      rd(2'd3, 16'h0007, "raw_ro");
      Btn = 3'b101;
      tick(2);
      rd(2'd3, 16'h0005, "raw_101");
      rd(2'd0, 16'h0007, "state_mid");

      // Reset in the middle of bit 1's release count discards it.
      tick(2);
      Reset = 1'b0;
      tick(1);
      Reset = 1'b1;
      rd(2'd0, 16'h0000, "rst_mid_state");
      rd(2'd1, 16'h0000, "rst_mid_event");
      tick(5); rd(2'd0, 16'h0000, "post_rst_e5");
      tick(1); rd(2'd0, 16'h0005, "post_rst_e6");
      tick(1); rd(2'd1, 16'h0005, "post_rst_e7");
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
